// File: rtl/mc_maindec_if.sv
// Bus between the multicycle main controller and the datapath / memory.
// The controller side (master) takes the opcode and memory handshake and
// drives all datapath strobes and multiplexer selects.
interface mc_maindec_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal;

    modport master (
        input  op, mem_ready,
        output mem_req, iord, irwrite, pcwrite, branch, memwrite, regwrite,
               regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop, illegal
    );

    modport slave (
        output op, mem_ready,
        input  mem_req, iord, irwrite, pcwrite, branch, memwrite, regwrite,
               regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop, illegal
    );
endinterface

// File: rtl/mc_maindec.sv
// Multicycle MIPS main-control FSM. Moore outputs, except the FETCH
// irwrite/pcwrite strobes which wait for mem_ready.
//
// state     | meaning
// ----------+----------------------------------------------
// S_FETCH   | read instruction at PC, PC+4 on mem_ready
// S_DECODE  | read registers, precompute branch target
// S_MEMADR  | compute lw/sw effective address
// S_MEMRD   | data read, wait for mem_ready
// S_MEMWB   | write loaded data to rt
// S_MEMWR   | data write, wait for mem_ready
// S_RTYPEEX | ALU op selected by funct
// S_RTYPEWB | write ALU result to rd
// S_BEQEX   | compare and conditionally branch
// S_ADDIEX  | add sign-extended immediate
// S_ADDIWB  | write sum to rt
// S_JEX     | load jump target into PC
module mc_maindec (
    input  logic        clk,
    input  logic        reset,
    mc_maindec_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state, state_nxt;
    logic   illegal_q;
    logic   op_known;

    assign op_known = (bus.op == OP_RTYPE) || (bus.op == OP_LW) || (bus.op == OP_SW) ||
                      (bus.op == OP_BEQ) || (bus.op == OP_ADDI) || (bus.op == OP_J);

    // State register; reset drops any in-flight instruction back to FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_nxt;
    end

    // Sticky unsupported-opcode flag, set on leaving DECODE with a bad op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              illegal_q <= 1'b0;
        else if (state == S_DECODE && !op_known) illegal_q <= 1'b1;
    end

    assign bus.illegal = illegal_q;

    // Next-state decode; memory states hold until mem_ready.
    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:   state_nxt = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_RTYPEEX;
                    OP_BEQ:       state_nxt = S_BEQEX;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JEX;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.op == OP_LW)      state_nxt = S_MEMRD;
                else if (bus.op == OP_SW) state_nxt = S_MEMWR;
                else                      state_nxt = S_FETCH;
            end
            S_MEMRD:   state_nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_nxt = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_nxt = S_RTYPEWB;
            S_ADDIEX:  state_nxt = S_ADDIWB;
            default:   state_nxt = S_FETCH;
        endcase
    end

    // Per-state strobes and selects; reset low forces every strobe off at once.
    always_comb begin
        bus.mem_req  = 1'b0;
        bus.iord     = 1'b0;
        bus.irwrite  = 1'b0;
        bus.pcwrite  = 1'b0;
        bus.branch   = 1'b0;
        bus.memwrite = 1'b0;
        bus.regwrite = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.pcsrc    = 2'b00;
        bus.aluop    = 2'b00;
        case (state)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.alusrcb = 2'b01;
                bus.irwrite = bus.mem_ready;
                bus.pcwrite = bus.mem_ready;
            end
            S_DECODE:  bus.alusrcb = 2'b11;
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            S_MEMWB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_req  = 1'b1;
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b10;
            end
            S_RTYPEWB: begin
                bus.regwrite = 1'b1;
                bus.regdst   = 1'b1;
            end
            S_BEQEX: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b01;
                bus.pcsrc   = 2'b01;
                bus.branch  = 1'b1;
            end
            S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_ADDIWB:  bus.regwrite = 1'b1;
            S_JEX: begin
                bus.pcsrc   = 2'b10;
                bus.pcwrite = 1'b1;
            end
            default: ;
        endcase
        if (!reset) begin
            bus.mem_req  = 1'b0;
            bus.irwrite  = 1'b0;
            bus.pcwrite  = 1'b0;
            bus.branch   = 1'b0;
            bus.memwrite = 1'b0;
            bus.regwrite = 1'b0;
        end
    end
endmodule

// File: tb/tb_mc_maindec.sv
// Bench for mc_maindec: instruction-level model builds the expected output
// trace cycle by cycle; the driving process compares it at each falling edge.
module tb_mc_maindec;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mc_maindec_if bus ();

    mc_maindec dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    int errors = 0;
    int checks = 0;
    int cyc_count = 0;
    int memwrite_cnt = 0;
    int regwrite_cnt = 0;
    int irwrite_cnt = 0;
    bit m_illegal = 1'b0;

    logic [16:0] act;
    assign act = {bus.mem_req, bus.iord, bus.irwrite, bus.pcwrite, bus.branch,
                  bus.memwrite, bus.regwrite, bus.regdst, bus.memtoreg, bus.alusrca,
                  bus.alusrcb, bus.pcsrc, bus.aluop, bus.illegal};

    function automatic logic [16:0] v(input logic mreq, input logic iord, input logic irw,
                                      input logic pcw, input logic br, input logic mw,
                                      input logic rw, input logic rd, input logic m2r,
                                      input logic asa, input logic [1:0] asb,
                                      input logic [1:0] pcs, input logic [1:0] aop);
        return {mreq, iord, irw, pcw, br, mw, rw, rd, m2r, asa, asb, pcs, aop, 1'b0};
    endfunction

    // Expected vectors, one per instruction step.
    logic [16:0] V_RST, V_FWAIT, V_FETCH, V_DEC, V_MEMADR, V_MEMRD, V_MEMWB, V_MEMWR;
    logic [16:0] V_RTEX, V_RTWB, V_BEQ, V_ADDIEX, V_ADDIWB, V_JEX;
    initial begin
        V_RST    = v(0,0,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00);
        V_FWAIT  = v(1,0,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00);
        V_FETCH  = v(1,0,1,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00);
        V_DEC    = v(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00);
        V_MEMADR = v(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
        V_MEMRD  = v(1,1,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
        V_MEMWB  = v(0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00);
        V_MEMWR  = v(1,1,0,0,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00);
        V_RTEX   = v(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 2'b10);
        V_RTWB   = v(0,0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 2'b00);
        V_BEQ    = v(0,0,0,0,1,0,0,0,0,1, 2'b00, 2'b01, 2'b01);
        V_ADDIEX = v(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
        V_ADDIWB = v(0,0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00);
        V_JEX    = v(0,0,0,1,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00);
    end

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs at the falling edge.
    task automatic step(input string name, input logic mr, input logic [16:0] e);
        logic [16:0] ev;
        bus.mem_ready = mr;
        ev = e | 17'(m_illegal);
        @(negedge clk);
        checks++;
        if (act !== ev) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %b want %b", name, cyc_count, act, ev);
        end
        if (bus.memwrite === 1'b1) memwrite_cnt++;
        if (bus.regwrite === 1'b1) regwrite_cnt++;
        if (bus.irwrite === 1'b1)  irwrite_cnt++;
        cyc_count++;
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset(input int n);
        reset = 1'b0;
        m_illegal = 1'b0;
        repeat (n) step("reset", 1'b1, V_RST);
        reset = 1'b1;
    endtask

    // Model of one instruction: fw FETCH wait cycles, mw data-memory wait cycles,
    // idle_mr driven on mem_ready in states that must ignore it.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input logic idle_mr, output int ncyc);
        int start;
        start = cyc_count;
        bus.op = op;
        repeat (fw) step("fetch_wait", 1'b0, V_FWAIT);
        step("fetch", 1'b1, V_FETCH);
        step("decode", idle_mr, V_DEC);
        case (op)
            OP_LW: begin
                step("lw_memadr", idle_mr, V_MEMADR);
                repeat (mw) step("lw_memrd_wait", 1'b0, V_MEMRD);
                step("lw_memrd", 1'b1, V_MEMRD);
                step("lw_memwb", idle_mr, V_MEMWB);
            end
            OP_SW: begin
                step("sw_memadr", idle_mr, V_MEMADR);
                repeat (mw) step("sw_memwr_wait", 1'b0, V_MEMWR);
                step("sw_memwr", 1'b1, V_MEMWR);
            end
            OP_RTYPE: begin
                step("rtype_ex", idle_mr, V_RTEX);
                step("rtype_wb", idle_mr, V_RTWB);
            end
            OP_BEQ:  step("beq_ex", idle_mr, V_BEQ);
            OP_ADDI: begin
                step("addi_ex", idle_mr, V_ADDIEX);
                step("addi_wb", idle_mr, V_ADDIWB);
            end
            OP_J:    step("j_ex", idle_mr, V_JEX);
            default: m_illegal = 1'b1;
        endcase
        ncyc = cyc_count - start;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.op = OP_RTYPE;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        hold_reset(3);

        irwrite_cnt = 0; regwrite_cnt = 0;
        run_instr(OP_LW, 0, 0, 1'b1, n);
        check_int("lw_latency", n, 5);
        check_int("lw_irwrite_pulses", irwrite_cnt, 1);
        check_int("lw_regwrite_cycles", regwrite_cnt, 1);

        memwrite_cnt = 0; regwrite_cnt = 0;
        run_instr(OP_SW, 0, 3, 1'b1, n);
        check_int("sw_latency_3wait", n, 7);
        check_int("sw_memwrite_cycles", memwrite_cnt, 4);
        check_int("sw_regwrite_cycles", regwrite_cnt, 0);

        run_instr(OP_RTYPE, 2, 0, 1'b0, n);
        check_int("rtype_latency_2fwait", n, 6);
        run_instr(OP_BEQ, 0, 0, 1'b1, n);
        check_int("beq_latency", n, 3);

        run_instr(6'b111111, 0, 0, 1'b1, n);
        check_int("illegal_latency", n, 2);
        check_int("illegal_flag_set", int'(bus.illegal), 1);
        run_instr(OP_ADDI, 0, 0, 1'b0, n);
        check_int("addi_latency", n, 4);
        check_int("illegal_flag_sticky", int'(bus.illegal), 1);

        irwrite_cnt = 0;
        run_instr(OP_LW, 1, 2, 1'b0, n);
        check_int("lw_latency_waits", n, 8);
        check_int("lw_wait_irwrite_pulses", irwrite_cnt, 1);
        run_instr(OP_SW, 0, 0, 1'b0, n);
        check_int("sw_latency", n, 4);

        // Jump, then reset asserted in the middle of JEX.
        bus.op = OP_J;
        step("j_fetch", 1'b1, V_FETCH);
        step("j_decode", 1'b1, V_DEC);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (act !== (V_JEX | 17'(m_illegal))) begin
            errors++;
            $display("FAIL j_ex: got %b want %b", act, V_JEX | 17'(m_illegal));
        end
        #1 reset = 1'b0;
        #1;
        check_int("jex_reset_pcwrite", int'(bus.pcwrite), 0);
        check_int("jex_reset_alusrcb", int'(bus.alusrcb), 1);
        check_int("jex_reset_pcsrc", int'(bus.pcsrc), 0);
        check_int("jex_reset_illegal", int'(bus.illegal), 0);
        @(posedge clk);
        #1;
        hold_reset(2);
        run_instr(OP_ADDI, 0, 0, 1'b1, n);
        check_int("post_reset_addi_latency", n, 4);
        run_instr(OP_J, 0, 0, 1'b0, n);
        check_int("j_latency", n, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
